// File: rtl/ads8689_emu.sv
`default_nettype none
// ============================================================================
// Module   : ads8689_emu
// Purpose  : Behavioural emulation of an ADS8689 ADC: CONVST-driven conversion,
//            32-bit SPI frame (mode 0, no CS) and RANGE_SEL register decode.
// Revision : 1.0 - initial release
// ============================================================================
module ads8689_emu #(
   parameter int         CONV_CYCLES = 33,
   parameter logic [8:0] RANGE_ADDR  = 9'h014
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic [15:0] adc_sample,
   input  logic        CONVST,
   input  logic        ADC_RST,
   output logic        RVS,
   input  logic        sclk,
   input  logic        sdi,
   output logic        sdo,
   output logic [3:0]  range_sel,
   output logic        frame_done,
   output logic        cfg_wr,
   output logic        cmd_err,
   output logic        frame_abort
);

   typedef enum logic [1:0] {
      XFER = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [6:0] c_op_write = 7'b1101010;
   localparam logic [6:0] c_op_nop   = 7'b0000000;
   localparam logic [9:0] c_conv_last = 10'(CONV_CYCLES - 1);

   state_t      r_state;
   state_t      w_next_state;

   logic [1:0]  r_convst_sync;
   logic [1:0]  r_adcrst_sync;
   logic [1:0]  r_sclk_sync;
   logic [1:0]  r_sdi_sync;
   logic        r_convst_q;
   logic        r_sclk_q;

   logic [5:0]  r_bit_cnt;
   logic [9:0]  r_conv_cnt;
   logic [31:0] r_rx;
   logic [31:0] r_tx;
   logic [15:0] r_conv_reg;
   logic [3:0]  r_range_sel;
   logic        r_rvs;
   logic        r_decode_pend;
   logic        r_frame_done;
   logic        r_cfg_wr;
   logic        r_cmd_err;
   logic        r_frame_abort;

   logic        w_soft_rst;
   logic        w_convst_rise;
   logic        w_sclk_rise;
   logic        w_sclk_fall;
   logic        w_start;
   logic        w_conv_end;
   logic        w_sclk_ok;
   logic        w_shift_in;
   logic        w_shift_out;
   logic        w_last_bit;
   logic [31:0] w_rx_next;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_convst_sync <= 2'b00;
         r_adcrst_sync <= 2'b00;
         r_sclk_sync   <= 2'b00;
         r_sdi_sync    <= 2'b00;
         r_convst_q    <= 1'b0;
         r_sclk_q      <= 1'b0;
      end else begin
         r_convst_sync <= {r_convst_sync[0], CONVST};
         r_adcrst_sync <= {r_adcrst_sync[0], ADC_RST};
         r_sclk_sync   <= {r_sclk_sync[0], sclk};
         r_sdi_sync    <= {r_sdi_sync[0], sdi};
         r_convst_q    <= r_convst_sync[1];
         r_sclk_q      <= r_sclk_sync[1];
      end
   end

   assign w_soft_rst    = ~r_adcrst_sync[1];
   assign w_convst_rise = r_convst_sync[1] & ~r_convst_q;
   assign w_sclk_rise   = r_sclk_sync[1] & ~r_sclk_q;
   assign w_sclk_fall   = ~r_sclk_sync[1] & r_sclk_q;

   // A synchronized-high CONVST blocks sclk, which also lets a same-cycle CONVST rise win.
   assign w_start     = w_convst_rise && (r_state != CONV);
   assign w_conv_end  = (r_state == CONV) && (r_conv_cnt == c_conv_last);
   assign w_sclk_ok   = (r_state == XFER) && !r_convst_sync[1];
   assign w_shift_in  = w_sclk_ok && w_sclk_rise;
   assign w_shift_out = w_sclk_ok && w_sclk_fall;
   assign w_last_bit  = w_shift_in && (r_bit_cnt == 6'd31);
   assign w_rx_next   = {r_rx[30:0], r_sdi_sync[1]};

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= XFER;
      end else if (w_soft_rst) begin
         r_state <= XFER;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         XFER: begin
            if (w_start) begin
               w_next_state = CONV;
            end else if (w_last_bit) begin
               w_next_state = DONE;
            end
         end
         CONV: begin
            if (w_conv_end) begin
               w_next_state = XFER;
            end
         end
         DONE: begin
            if (w_start) begin
               w_next_state = CONV;
            end
         end
         default: w_next_state = XFER;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt     <= 6'd0;
         r_conv_cnt    <= 10'd0;
         r_rx          <= 32'd0;
         r_tx          <= 32'd0;
         r_conv_reg    <= 16'd0;
         r_range_sel   <= 4'h0;
         r_rvs         <= 1'b0;
         r_decode_pend <= 1'b0;
         r_frame_done  <= 1'b0;
         r_cfg_wr      <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_frame_abort <= 1'b0;
      end else if (w_soft_rst) begin
         r_bit_cnt     <= 6'd0;
         r_conv_cnt    <= 10'd0;
         r_rx          <= 32'd0;
         r_tx          <= 32'd0;
         r_conv_reg    <= 16'd0;
         r_range_sel   <= 4'h0;
         r_rvs         <= 1'b0;
         r_decode_pend <= 1'b0;
         r_frame_done  <= 1'b0;
         r_cfg_wr      <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_frame_abort <= 1'b0;
      end else begin
         r_frame_done  <= 1'b0;
         r_cfg_wr      <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_frame_abort <= 1'b0;

         // Decode reads the word assembled on the previous edge, even if a conversion starts now.
         if (r_decode_pend) begin
            r_decode_pend <= 1'b0;
            if (r_rx[31:25] == c_op_write) begin
               if (r_rx[24:16] == RANGE_ADDR) begin
                  r_range_sel <= r_rx[3:0];
                  r_cfg_wr    <= 1'b1;
               end
            end else if (r_rx[31:25] != c_op_nop) begin
               r_cmd_err <= 1'b1;
            end
         end

         if (w_start) begin
            r_conv_reg    <= adc_sample;
            r_bit_cnt     <= 6'd0;
            r_rx          <= 32'd0;
            r_conv_cnt    <= 10'd0;
            r_rvs         <= 1'b0;
            r_frame_abort <= (r_state == XFER) && (r_bit_cnt != 6'd0) && (r_bit_cnt < 6'd32);
         end else if (r_state == CONV) begin
            r_conv_cnt <= r_conv_cnt + 10'd1;
            if (w_conv_end) begin
               r_rvs <= 1'b1;
               r_tx  <= {r_conv_reg, 12'h000, r_range_sel};
            end
         end else if (w_shift_in) begin
            r_rx      <= w_rx_next;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (w_last_bit) begin
               r_rvs         <= 1'b0;
               r_frame_done  <= 1'b1;
               r_decode_pend <= 1'b1;
            end
         end else if (w_shift_out) begin
            r_tx <= {r_tx[30:0], 1'b0};
         end
      end
   end

   assign RVS         = r_rvs;
   assign sdo         = r_tx[31];
   assign range_sel   = r_range_sel;
   assign frame_done  = r_frame_done;
   assign cfg_wr      = r_cfg_wr;
   assign cmd_err     = r_cmd_err;
   assign frame_abort = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_ads8689_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads8689_emu
// Purpose  : Directed + randomized bench for ads8689_emu with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads8689_emu;

   localparam int         CONV_CYCLES = 33;
   localparam logic [8:0] RANGE_ADDR  = 9'h014;

   logic        clk_50m    = 1'b0;
   logic        rst_n      = 1'b0;
   logic [15:0] adc_sample = 16'h0000;
   logic        CONVST     = 1'b0;
   logic        ADC_RST    = 1'b1;
   logic        sclk       = 1'b0;
   logic        sdi        = 1'b0;
   logic        RVS;
   logic        sdo;
   logic [3:0]  range_sel;
   logic        frame_done;
   logic        cfg_wr;
   logic        cmd_err;
   logic        frame_abort;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int cyc = 0;
   int n_fd = 0;
   int n_cw = 0;
   int n_ce = 0;
   int n_ab = 0;
   int last_fd_cyc = 0;
   int cw_gap = 0;

   // Frame-level model: current range register and the response the next frame returns.
   logic [3:0]  m_range = 4'h0;
   logic [31:0] m_resp  = 32'h0;

   ads8689_emu #(
      .CONV_CYCLES (CONV_CYCLES),
      .RANGE_ADDR  (RANGE_ADDR)
   ) dut (
      .clk_50m     (clk_50m),
      .rst_n       (rst_n),
      .adc_sample  (adc_sample),
      .CONVST      (CONVST),
      .ADC_RST     (ADC_RST),
      .RVS         (RVS),
      .sclk        (sclk),
      .sdi         (sdi),
      .sdo         (sdo),
      .range_sel   (range_sel),
      .frame_done  (frame_done),
      .cfg_wr      (cfg_wr),
      .cmd_err     (cmd_err),
      .frame_abort (frame_abort)
   );

   always #10 clk_50m = ~clk_50m;

   always @(negedge clk_50m) begin
      cyc = cyc + 1;
      if (frame_done === 1'b1) begin
         n_fd = n_fd + 1;
         last_fd_cyc = cyc;
      end
      if (cfg_wr === 1'b1) begin
         n_cw = n_cw + 1;
         cw_gap = cyc - last_fd_cyc;
      end
      if (cmd_err === 1'b1) n_ce = n_ce + 1;
      if (frame_abort === 1'b1) n_ab = n_ab + 1;
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog: observed timeout expected finish (%0d/%0d checks passed so far)", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic so);
      sdi = b;
      repeat (8) @(negedge clk_50m);
      so   = sdo;
      sclk = 1'b1;
      repeat (8) @(negedge clk_50m);
      sclk = 1'b0;
   endtask

   task automatic spi_frame(input logic [31:0] cmd, input int nbits, output logic [31:0] resp);
      logic so;
      resp = 32'h0;
      for (int i = 0; i < nbits; i++) begin
         spi_bit(cmd[31-i], so);
         resp = {resp[30:0], so};
      end
      repeat (6) @(negedge clk_50m);
   endtask

   task automatic do_conv(input logic [15:0] s, input bit repulse, input logic [15:0] s2,
                          input string tag);
      int k;
      bit low_seen;
      @(negedge clk_50m);
      adc_sample = s;
      CONVST = 1'b1;
      k = 0;
      low_seen = 1'b0;
      while (k < 2000 && !(k > 4 && RVS === 1'b1)) begin
         @(negedge clk_50m);
         k = k + 1;
         if (k >= 3 && k <= 4 && RVS === 1'b0) low_seen = 1'b1;
         if (k == 8) CONVST = 1'b0;
         if (repulse && k == 14) begin
            CONVST = 1'b1;
            adc_sample = s2;
         end
         if (repulse && k == 20) CONVST = 1'b0;
      end
      check({tag, " rvs_low"}, 32'(low_seen), 32'd1);
      check({tag, " rvs_rise_cycle"}, 32'(k), 32'(CONV_CYCLES + 3));
      CONVST = 1'b0;
      repeat (4) @(negedge clk_50m);
      m_resp = {s, 12'h000, m_range};
   endtask

   task automatic frame_check(input string tag, input logic [31:0] cmd);
      int fd0;
      int cw0;
      int ce0;
      logic [31:0] resp;
      bit exp_cw;
      bit exp_ce;
      fd0 = n_fd;
      cw0 = n_cw;
      ce0 = n_ce;
      exp_cw = 1'b0;
      exp_ce = 1'b0;
      spi_frame(cmd, 32, resp);
      if (cmd[31:25] == 7'b1101010) begin
         if (cmd[24:16] == RANGE_ADDR) begin
            exp_cw  = 1'b1;
            m_range = cmd[3:0];
         end
      end else if (cmd[31:25] != 7'b0000000) begin
         exp_ce = 1'b1;
      end
      check({tag, " sdo_word"}, resp, m_resp);
      check({tag, " range_sel"}, 32'(range_sel), 32'(m_range));
      check({tag, " frame_done"}, 32'(n_fd - fd0), 32'd1);
      check({tag, " cfg_wr"}, 32'(n_cw - cw0), 32'(exp_cw));
      check({tag, " cmd_err"}, 32'(n_ce - ce0), 32'(exp_ce));
      check({tag, " rvs_after"}, 32'(RVS), 32'd0);
      if (exp_cw) check({tag, " cfg_wr_gap"}, 32'(cw_gap), 32'd1);
   endtask

   initial begin
      logic [31:0] resp;
      logic [31:0] cmd;
      logic [15:0] s;
      logic [6:0]  op;
      logic        so;
      logic        sdo_before;
      int          fd0;
      int          cw0;
      int          ab0;
      int          t;

      repeat (3) @(negedge clk_50m);
      check("reset_outputs",
            32'({RVS, sdo, range_sel, frame_done, cfg_wr, cmd_err, frame_abort}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_50m);

      // First frame after reset returns zeros and writes range 4.
      frame_check("first_frame", 32'hD414_0004);
      check("first_frame range4", 32'(range_sel), 32'h4);

      do_conv(16'hA5C3, 1'b0, 16'h0000, "conv_a5c3");
      check("conv_a5c3 model_word", m_resp, 32'hA5C3_0004);
      frame_check("nop_a5c3", 32'h0000_0000);

      // Second CONVST pulse during CONV must be ignored.
      do_conv(16'h1234, 1'b1, 16'hBEEF, "conv_repulse");
      frame_check("nop_repulse", 32'h0155_AAAA);

      // Partial frame aborted by CONVST.
      do_conv(16'($urandom), 1'b0, 16'h0000, "conv_pre_abort");
      spi_frame(32'hD414_0009, 12, resp);
      ab0 = n_ab;
      cw0 = n_cw;
      do_conv(16'($urandom), 1'b0, 16'h0000, "conv_abort");
      check("abort pulse", 32'(n_ab - ab0), 32'd1);
      check("abort no_cfg_wr", 32'(n_cw - cw0), 32'd0);
      check("abort range_kept", 32'(range_sel), 32'(m_range));
      frame_check("after_abort", {7'b1101010, RANGE_ADDR, 12'h000, 4'h7});

      // Bad opcode, then an extra sclk while in DONE.
      do_conv(16'($urandom), 1'b0, 16'h0000, "conv_badop");
      frame_check("bad_op", 32'hFFFF_0000);
      sdo_before = sdo;
      fd0 = n_fd;
      spi_bit(1'b1, so);
      repeat (6) @(negedge clk_50m);
      check("done sdo_before", 32'(sdo_before), 32'(m_resp[0]));
      check("done sdo_after", 32'(sdo), 32'(m_resp[0]));
      check("done no_frame", 32'(n_fd - fd0), 32'd0);

      for (int i = 0; i < 6; i++) begin
         s = 16'($urandom);
         do_conv(s, 1'b0, 16'h0000, "rand_conv");
         t = int'($urandom_range(0, 3));
         case (t)
            0: cmd = {7'b1101010, RANGE_ADDR, 12'($urandom), 4'($urandom)};
            1: cmd = {7'b1101010, RANGE_ADDR + 9'($urandom_range(1, 511)), 16'($urandom)};
            2: cmd = {7'b0000000, 25'($urandom)};
            default: begin
               op = 7'($urandom);
               if (op == 7'b0000000 || op == 7'b1101010) op = 7'h55;
               cmd = {op, 25'($urandom)};
            end
         endcase
         frame_check("rand_frame", cmd);
      end

      // ADC_RST clears range and status; the block is then ready for a fresh frame.
      do_conv(16'($urandom), 1'b0, 16'h0000, "conv_pre_adcrst");
      frame_check("set_range4", {7'b1101010, RANGE_ADDR, 12'h000, 4'h4});
      ADC_RST = 1'b0;
      repeat (10) @(negedge clk_50m);
      check("adcrst range_sel", 32'(range_sel), 32'h0);
      check("adcrst rvs", 32'(RVS), 32'd0);
      check("adcrst sdo", 32'(sdo), 32'd0);
      ADC_RST = 1'b1;
      repeat (5) @(negedge clk_50m);
      m_range = 4'h0;
      m_resp  = 32'h0;
      frame_check("post_adcrst", {7'b1101010, RANGE_ADDR, 12'h000, 4'h9});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ads8689_emu.md
ADS8689_EMU -- requirements
Module: ads8689_emu

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 33: clk_50m cycles from detected CONVST rise to end of conversion (legal range 4..1023).
REQ-002 SHALL have parameter RANGE_ADDR, default 9'h014: register address that a WRITE command decodes to update range_sel.
REQ-003 SHALL have port clk_50m  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc_sample  input  16  value captured as the conversion result.
REQ-006 SHALL have port CONVST  input  1  conversion start from host, asynchronous to clk_50m.
REQ-007 SHALL have port ADC_RST  input  1  device reset from host, active-low, asynchronous to clk_50m.
REQ-008 SHALL have port RVS  output  1  ready/valid status: high = result ready and frame armed.
REQ-009 SHALL have port sclk  input  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0), no chip select.
REQ-010 SHALL have port sdi  input  1  command data from host (MOSI), MSB first.
REQ-011 SHALL have port sdo  output  1  response data to host (MISO), MSB first.
REQ-012 SHALL have port range_sel  output  4  current RANGE_SEL register field.
REQ-013 SHALL have ports frame_done, cfg_wr, cmd_err, frame_abort  output  1 each  one-cycle status pulses.

Function
REQ-014 CONVST, ADC_RST, sclk and sdi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized copies; sdi is sampled from its synchronized copy in the same cycle the sclk rise is detected.
REQ-015 FSM states SHALL be XFER (frame armed, bits counted), CONV (conversion running) and DONE (frame complete, sclk ignored); post-reset state is XFER.
REQ-016 Detected CONVST rise in XFER or DONE SHALL go to CONV, latch adc_sample into conv_reg, clear bit counter and rx shift register, and drive RVS low next cycle.
REQ-017 A CONVST rise while in XFER with bit counter in 1..31 SHALL additionally pulse frame_abort; the partial frame is discarded with no decode.
REQ-018 A CONVST rise while in CONV SHALL be ignored.
REQ-019 CONV SHALL last exactly CONV_CYCLES cycles, then go to XFER, set RVS high, and load tx shift register with {conv_reg, 12'h000, range_sel}.
REQ-020 In XFER each detected sclk rise SHALL shift sdi into the 32-bit rx register LSB side and increment the 6-bit bit counter; each detected sclk fall SHALL shift tx left, filling with 0.
REQ-021 sdo SHALL equal tx[31] continuously, so bit 31 is valid before the first sclk rise.
REQ-022 sclk edges in CONV or DONE SHALL be ignored; no shifting, no count.
REQ-023 On the 32nd sclk rise the block SHALL go to DONE, drive RVS low, pulse frame_done, and decode the assembled 32-bit word w the following cycle.
REQ-024 Decode: w[31:25]=7'b1101010 and w[24:16]=RANGE_ADDR SHALL set range_sel<=w[3:0] and pulse cfg_wr; w[31:25]=7'b1101010 with another address SHALL be accepted without effect.
REQ-025 Decode: w[31:25]=7'b0000000 SHALL be NOP (no effect); any other opcode SHALL pulse cmd_err and change nothing.
REQ-026 Frames SHALL be counted only while CONVST is low; a frame without a preceding conversion (first after reset) SHALL return all-zero data and still decode.
REQ-027 A CONVST rise and an sclk edge detected in the same cycle: the CONVST rise SHALL win and the sclk edge is dropped.

Reset
REQ-028 rst_n low SHALL asynchronously force: state XFER, bit counter 0, rx 0, tx 0, conv_reg 0, range_sel 4'h0, RVS 0, sdo 0, all pulses 0, synchronizer flops 0.
REQ-029 Synchronized ADC_RST low SHALL apply the same values synchronously and hold them while low; rst_n mid-frame or mid-conversion SHALL discard all progress.

Verification
REQ-030 Reset then 32 sclk cycles (period 16 clk) with sdi word 32'hD4140004 -> frame_done, cfg_wr one cycle later, range_sel=4'h4, sdo returned 32'h0000_0000.
REQ-031 adc_sample=16'hA5C3, CONVST high -> RVS low within 4 cycles, high after CONV_CYCLES; CONVST low, NOP frame -> sdo sequence 32'hA5C3_0004, RVS low after 32nd bit.
REQ-032 CONVST pulsed again during CONV -> no new latch, RVS rise timing unchanged.
REQ-033 12 sclk cycles then CONVST rise -> frame_abort pulse, no cfg_wr, next full frame decodes normally.
REQ-034 Frame 32'hFFFF_0000 -> cmd_err pulse, range_sel unchanged; extra sclk after 32 bits in DONE -> sdo and counters unchanged.
REQ-035 ADC_RST low for 10 cycles with range_sel=4 -> range_sel=0, RVS=0, state XFER with counter 0.
